// File: rtl/sram_1rw_arbiter.sv
// Round-robin read/write arbiter in front of a 1RW SRAM macro, with a credit-checked read-response FIFO.
// Define SRAM_INIT_EN to zero the whole macro after reset before accepting requests.
module sram_1rw_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16384,
    parameter int RESP_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_done,
    output logic [0:0]        dbg_state
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_W");
    end

    // Handshakes: a request transfers in a cycle where valid && ready; ready is
    // combinational on both request valids, so valid must never wait on ready.
    // The response side pops the FIFO head in a cycle where valid && ready.

    logic [0:0]        state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic              inflight_q;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] fifo_q [RESP_DEPTH];

    logic rd_elig;
    logic grant_rd;
    logic grant_wr;
    logic push;
    logic pop;

`ifdef SRAM_INIT_EN
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
`endif

    // Credit counts queued entries plus the read still in the macro; a pop in
    // this same cycle is deliberately ignored to keep resp_ready off the req_ready path.
    assign rd_elig = rd_req_valid && ((count_q + CW'(inflight_q)) < CW'(RESP_DEPTH));

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        if (state_q == ST_RUN) begin
            if (rd_elig && wr_req_valid) begin
                grant_rd  = last_wr_q;
                grant_wr  = !last_wr_q;
                last_wr_d = !last_wr_q;
            end else begin
                grant_rd = rd_elig;
                grant_wr = wr_req_valid;
            end
        end
    end

    always_comb begin
        sram_en    = grant_rd || grant_wr;
        sram_wmode = grant_wr;
        sram_addr  = grant_wr ? wr_req_addr : rd_req_addr;
        sram_wdata = grant_wr ? wr_req_data : '0;
`ifdef SRAM_INIT_EN
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            sram_en     = reset_n;
            sram_wmode  = 1'b1;
            sram_addr   = init_addr_q;
            sram_wdata  = '0;
            init_addr_d = init_addr_q + ADDR_W'(1);
        end
`endif
    end

`ifdef SRAM_INIT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_addr_q <= '0;
        end else begin
            init_addr_q <= init_addr_d;
        end
    end

    // Leaves INIT once the last address has been written.
    logic [0:0] state_next;
    always_comb begin
        state_next = state_d;
        if ((state_q == ST_INIT) && (init_addr_q == ADDR_W'(DEPTH - 1))) begin
            state_next = ST_RUN;
        end
    end
    localparam logic [0:0] ST_RESET = ST_INIT;
`else
    logic [0:0] state_next;
    assign state_next = state_d;
    localparam logic [0:0] ST_RESET = ST_RUN;
`endif

    assign rd_req_ready = grant_rd;
    assign wr_req_ready = grant_wr;
    assign init_done    = (state_q == ST_RUN);
    assign dbg_state    = state_q;

    assign push          = inflight_q;
    assign rd_resp_valid = (count_q != '0);
    assign pop           = rd_resp_valid && rd_resp_ready;
    assign rd_resp_data  = fifo_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RESET;
            last_wr_q  <= 1'b1;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_next;
            last_wr_q  <= last_wr_d;
            inflight_q <= grant_rd;
            count_q    <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Macro read data is valid the cycle after the accepted read.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sram_rdata;
        end
    end

endmodule
